axi4_burst_initiator: RTL and testbench
=======================================

Name: axi4_burst_initiator

Overview:
- AXI4 master (initiator) that issues one INCR burst per command on the 64-bit memory port: the DDR path on the slave side, or a behavioural AXI4 slave on the bench.
- Used by boot-loader and memory-test logic to fill or read back DDR without the core.
- Takes a simple command (write or read, address, length) and streams write data in or read data out.
- Returns one completion pulse per command with an error flag.

Parameters:
- AXI_ID, 4'h0, constant ID driven on aw_id and ar_id; also the expected b_id and r_id.
- ADDR_MASK, 32'h07ffffff, ANDed onto cmd_addr before it drives aw_addr or ar_addr.

Ports:
- clock  in  1  single clock for the whole block.
- resetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block idle and accepting a command.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  32  byte address; bits [2:0] must be 0.
- cmd_len  in  8  number of beats minus 1 (AXI encoding).
- wdata_valid  in  1  write-data beat available.
- wdata_ready  out  1  write-data beat consumed.
- wdata  in  64  write data.
- wstrb  in  8  write byte strobes.
- rdata_valid  out  1  read-data beat valid.
- rdata_ready  in  1  downstream accepts the read beat.
- rdata  out  64  read data.
- rdata_last  out  1  final beat of the read burst.
- done_valid  out  1  one-cycle completion pulse.
- done_err  out  1  error flag, qualified by done_valid.
- io_axi4_0_aw_valid/aw_ready  out/in  1/1  write-address handshake.
- io_axi4_0_aw_id/addr/len/size/burst  out  4/32/8/3/2  AXI_ID / masked addr / cmd_len / 3'd3 / 2'b01.
- io_axi4_0_aw_lock/cache/prot/qos  out  1/4/3/4  constants 0 / 4'b0011 / 0 / 0.
- io_axi4_0_w_valid/w_ready  out/in  1/1  write-data handshake.
- io_axi4_0_w_data/w_strb/w_last  out  64/8/1  write beat.
- io_axi4_0_b_valid/b_ready  in/out  1/1  write-response handshake.
- io_axi4_0_b_id/b_resp  in  4/2  write response.
- io_axi4_0_ar_valid/ar_ready  out/in  1/1  read-address handshake.
- io_axi4_0_ar_id/addr/len/size/burst/lock/cache/prot/qos  out  same values as the aw channel.
- io_axi4_0_r_valid/r_ready  in/out  1/1  read-data handshake.
- io_axi4_0_r_id/r_data/r_resp/r_last  in  4/64/2/1  read beat.

Behaviour:
- Reset (resetn low, asynchronous): state IDLE; all valid and ready outputs 0; done_err 0; beat counter 0; error flag 0; address and length registers 0.
- Reset mid-burst abandons the transaction; the slave must be reset together with this block.
- States: IDLE, AW, W, B, AR, R, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch addr (masked), len and write.
  - If addr[2:0] != 0, or addr[11:0] + 8*(len+1) > 4096 (4 KB crossing): go to DONE with err = 1, no AXI traffic.
  - Otherwise go to AW (write) or AR (read).
- AW: aw_valid = 1 from the registered state, held stable until aw_ready. Handshake -> W with counter = 0.
- W:
  - w_valid = wdata_valid and wdata_ready = w_ready, both combinational, only in W.
  - w_last = (counter == len).
  - Each handshake increments the counter.
  - Handshake with w_last -> B.
  - No write data is issued before the AW handshake.
- B:
  - b_ready = 1.
  - On b_valid, err |= (b_resp != 2'b00) | (b_id != AXI_ID), then go to DONE.
- AR: ar_valid held until ar_ready, then R with counter = 0.
- R:
  - rdata_valid = r_valid; r_ready = rdata_ready; rdata = r_data; rdata_last = r_last.
  - Each handshake: err |= (r_resp != 0) | (r_id != AXI_ID) | (r_last != (counter == len)), and the counter increments.
  - On the beat where counter == len or r_last is set, go to DONE.
- DONE: done_valid = 1 and done_err = err for exactly one cycle; err clears; next state IDLE; cmd_ready = 0 in this cycle.
- Latency:
  - Minimum write = 1 (accept) + 1 (AW) + len+1 (W) + 1 (B) + 1 (DONE) cycles with zero-wait slave.
  - Minimum read = 1 + 1 + len+1 + 1.
- Only one outstanding transaction at a time; b and r channels are ready only in their own states.
- len = 255 (256 beats) is legal if no 4 KB crossing; the counter is 8 bits and never wraps within a burst.

Decomposition:
- Shared package holds:
  - state encoding.
  - AXI constants: BURST_INCR = 2'b01, SIZE_8B = 3'd3, CACHE_DEFAULT = 4'b0011, RESP_OKAY = 2'b00.
  - DDR_MASK default value.
- No sub-module: one FSM plus counter; the 4 KB check is inline combinational logic.

Test Plan:
- Write, addr 0x0000_1000, len 3, 4 data beats 0x11..0x44 with zero-wait slave -> aw_len = 3, w_last only on beat 4, done_valid after B with err = 0; reading back returns 0x11..0x44 in order.
- Read, addr 0x8000_0040 -> ar_addr = 0x0000_0040 (masked); random r_valid gaps and rdata_ready stalls -> no beat lost or duplicated, rdata_last on beat len+1.
- cmd addr 0x0000_0FF8, len 1 (crosses 4 KB) -> no aw_valid/ar_valid ever, done_err = 1 two cycles after the command is accepted.
- Slave returns b_resp = 2'b10 (SLVERR), or r_last early on beat 2 of len 3 -> done_err = 1, FSM back in IDLE, next command accepted.
- Assert resetn low during beat 5 of a 16-beat write -> w_valid and aw_valid drop immediately (asynchronously), cmd_ready = 1 after reset releases.
- len 255 write then read -> 256 beats each, counter reaches 255 with last asserted exactly once, err = 0.

Source files
------------

// File: rtl/axi4_burst_initiator_pkg.sv
// Shared definitions for the AXI4 burst initiator.
//   state_t        : FSM state encoding
//   BURST_INCR     : AXI INCR burst code
//   SIZE_8B        : AXI size code for 8-byte beats
//   CACHE_DEFAULT  : normal non-cacheable bufferable
//   RESP_OKAY      : AXI OKAY response
//   DDR_MASK       : default address window of the DDR port
package axi4_burst_initiator_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_AR,
    S_R,
    S_DONE
  } state_t;

  localparam logic [1:0]  BURST_INCR    = 2'b01;
  localparam logic [2:0]  SIZE_8B       = 3'd3;
  localparam logic [3:0]  CACHE_DEFAULT = 4'b0011;
  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [31:0] DDR_MASK      = 32'h07ff_ffff;

endpackage

// File: rtl/axi4_burst_initiator.sv
// AXI4 master issuing one INCR burst of 64-bit beats per command.
// Ports:
//   clock, resetn            : clock and async active-low reset
//   cmd_*                    : command (write/read, byte address, beats-1)
//   wdata_*, wstrb           : write-data stream in
//   rdata_*                  : read-data stream out
//   done_valid, done_err     : one-cycle completion pulse with error flag
//   io_axi4_0_*              : AXI4 master port
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | accepting a command
// AW     | write address presented, waiting for aw_ready
// W      | streaming write beats
// B      | waiting for the write response
// AR     | read address presented, waiting for ar_ready
// R      | streaming read beats
// DONE   | completion pulse, back to IDLE
module axi4_burst_initiator
  import axi4_burst_initiator_pkg::*;
#(
  parameter logic [3:0]  AXI_ID    = 4'h0,
  parameter logic [31:0] ADDR_MASK = DDR_MASK
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  output logic        rdata_valid,
  input  logic        rdata_ready,
  output logic [63:0] rdata,
  output logic        rdata_last,
  output logic        done_valid,
  output logic        done_err,
  output logic        io_axi4_0_aw_valid,
  input  logic        io_axi4_0_aw_ready,
  output logic [3:0]  io_axi4_0_aw_id,
  output logic [31:0] io_axi4_0_aw_addr,
  output logic [7:0]  io_axi4_0_aw_len,
  output logic [2:0]  io_axi4_0_aw_size,
  output logic [1:0]  io_axi4_0_aw_burst,
  output logic        io_axi4_0_aw_lock,
  output logic [3:0]  io_axi4_0_aw_cache,
  output logic [2:0]  io_axi4_0_aw_prot,
  output logic [3:0]  io_axi4_0_aw_qos,
  output logic        io_axi4_0_w_valid,
  input  logic        io_axi4_0_w_ready,
  output logic [63:0] io_axi4_0_w_data,
  output logic [7:0]  io_axi4_0_w_strb,
  output logic        io_axi4_0_w_last,
  input  logic        io_axi4_0_b_valid,
  output logic        io_axi4_0_b_ready,
  input  logic [3:0]  io_axi4_0_b_id,
  input  logic [1:0]  io_axi4_0_b_resp,
  output logic        io_axi4_0_ar_valid,
  input  logic        io_axi4_0_ar_ready,
  output logic [3:0]  io_axi4_0_ar_id,
  output logic [31:0] io_axi4_0_ar_addr,
  output logic [7:0]  io_axi4_0_ar_len,
  output logic [2:0]  io_axi4_0_ar_size,
  output logic [1:0]  io_axi4_0_ar_burst,
  output logic        io_axi4_0_ar_lock,
  output logic [3:0]  io_axi4_0_ar_cache,
  output logic [2:0]  io_axi4_0_ar_prot,
  output logic [3:0]  io_axi4_0_ar_qos,
  input  logic        io_axi4_0_r_valid,
  output logic        io_axi4_0_r_ready,
  input  logic [3:0]  io_axi4_0_r_id,
  input  logic [63:0] io_axi4_0_r_data,
  input  logic [1:0]  io_axi4_0_r_resp,
  input  logic        io_axi4_0_r_last
);

  state_t      state;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [7:0]  beat_cnt;
  logic        err_q;
  logic        cmd_ready_q;

  logic [31:0] cmd_addr_m;
  logic [13:0] burst_end;
  logic        cmd_bad;
  logic        cmd_fire;
  logic        last_beat;
  logic        w_fire;
  logic        r_fire;
  logic        b_bad;
  logic        r_bad;

  assign cmd_addr_m = cmd_addr & ADDR_MASK;
  // Offset of the first byte past the burst within the 4 KB page.
  assign burst_end  = {2'b00, cmd_addr_m[11:0]} + {3'b000, cmd_len, 3'b000} + 14'd8;
  assign cmd_bad    = (cmd_addr_m[2:0] != 3'b000) || (burst_end > 14'd4096);
  assign cmd_fire   = cmd_valid && cmd_ready_q;
  assign last_beat  = (beat_cnt == len_q);
  assign w_fire     = (state == S_W) && wdata_valid && io_axi4_0_w_ready;
  assign r_fire     = (state == S_R) && io_axi4_0_r_valid && rdata_ready;
  assign b_bad      = (io_axi4_0_b_resp != RESP_OKAY) || (io_axi4_0_b_id != AXI_ID);
  // A beat is also bad when the slave's r_last disagrees with our own count.
  assign r_bad      = (io_axi4_0_r_resp != RESP_OKAY) || (io_axi4_0_r_id != AXI_ID) ||
                      (io_axi4_0_r_last != last_beat);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      beat_cnt    <= '0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      cmd_ready_q <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_fire) begin
            addr_q      <= cmd_addr_m;
            len_q       <= cmd_len;
            beat_cnt    <= '0;
            cmd_ready_q <= 1'b0;
            if (cmd_bad) begin
              err_q <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= cmd_write ? S_AW : S_AR;
            end
          end
        end
        S_AW: begin
          if (io_axi4_0_aw_ready) begin
            beat_cnt <= '0;
            state    <= S_W;
          end
        end
        S_W: begin
          if (w_fire) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (last_beat) state <= S_B;
          end
        end
        S_B: begin
          if (io_axi4_0_b_valid) begin
            err_q <= err_q | b_bad;
            state <= S_DONE;
          end
        end
        S_AR: begin
          if (io_axi4_0_ar_ready) begin
            beat_cnt <= '0;
            state    <= S_R;
          end
        end
        S_R: begin
          if (r_fire) begin
            err_q    <= err_q | r_bad;
            beat_cnt <= beat_cnt + 8'd1;
            if (last_beat || io_axi4_0_r_last) state <= S_DONE;
          end
        end
        S_DONE: begin
          err_q       <= 1'b0;
          cmd_ready_q <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign done_valid  = (state == S_DONE);
  assign done_err    = (state == S_DONE) && err_q;

  assign io_axi4_0_aw_valid = (state == S_AW);
  assign io_axi4_0_aw_id    = AXI_ID;
  assign io_axi4_0_aw_addr  = addr_q;
  assign io_axi4_0_aw_len   = len_q;
  assign io_axi4_0_aw_size  = SIZE_8B;
  assign io_axi4_0_aw_burst = BURST_INCR;
  assign io_axi4_0_aw_lock  = 1'b0;
  assign io_axi4_0_aw_cache = CACHE_DEFAULT;
  assign io_axi4_0_aw_prot  = 3'd0;
  assign io_axi4_0_aw_qos   = 4'd0;

  assign io_axi4_0_w_valid  = (state == S_W) && wdata_valid;
  assign wdata_ready        = (state == S_W) && io_axi4_0_w_ready;
  assign io_axi4_0_w_data   = wdata;
  assign io_axi4_0_w_strb   = wstrb;
  assign io_axi4_0_w_last   = (state == S_W) && last_beat;

  assign io_axi4_0_b_ready  = (state == S_B);

  assign io_axi4_0_ar_valid = (state == S_AR);
  assign io_axi4_0_ar_id    = AXI_ID;
  assign io_axi4_0_ar_addr  = addr_q;
  assign io_axi4_0_ar_len   = len_q;
  assign io_axi4_0_ar_size  = SIZE_8B;
  assign io_axi4_0_ar_burst = BURST_INCR;
  assign io_axi4_0_ar_lock  = 1'b0;
  assign io_axi4_0_ar_cache = CACHE_DEFAULT;
  assign io_axi4_0_ar_prot  = 3'd0;
  assign io_axi4_0_ar_qos   = 4'd0;

  assign rdata_valid        = (state == S_R) && io_axi4_0_r_valid;
  assign io_axi4_0_r_ready  = (state == S_R) && rdata_ready;
  assign rdata              = io_axi4_0_r_data;
  assign rdata_last         = (state == S_R) && io_axi4_0_r_last;

endmodule

// File: tb/tb_axi4_burst_initiator.sv
// Scoreboard bench for axi4_burst_initiator with a behavioural AXI4 slave.
module tb_axi4_burst_initiator;

  logic        clock, resetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wdata_valid, wdata_ready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        rdata_valid, rdata_ready, rdata_last;
  logic [63:0] rdata;
  logic        done_valid, done_err;
  logic        aw_valid, aw_ready, aw_lock;
  logic [3:0]  aw_id, aw_cache, aw_qos;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size, aw_prot;
  logic [1:0]  aw_burst;
  logic        w_valid, w_ready, w_last;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        b_valid, b_ready;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic        ar_valid, ar_ready, ar_lock;
  logic [3:0]  ar_id, ar_cache, ar_qos;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size, ar_prot;
  logic [1:0]  ar_burst;
  logic        r_valid, r_ready, r_last;
  logic [3:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;

  axi4_burst_initiator dut (
    .clock(clock), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wstrb(wstrb),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata), .rdata_last(rdata_last),
    .done_valid(done_valid), .done_err(done_err),
    .io_axi4_0_aw_valid(aw_valid), .io_axi4_0_aw_ready(aw_ready), .io_axi4_0_aw_id(aw_id),
    .io_axi4_0_aw_addr(aw_addr), .io_axi4_0_aw_len(aw_len), .io_axi4_0_aw_size(aw_size),
    .io_axi4_0_aw_burst(aw_burst), .io_axi4_0_aw_lock(aw_lock), .io_axi4_0_aw_cache(aw_cache),
    .io_axi4_0_aw_prot(aw_prot), .io_axi4_0_aw_qos(aw_qos),
    .io_axi4_0_w_valid(w_valid), .io_axi4_0_w_ready(w_ready), .io_axi4_0_w_data(w_data),
    .io_axi4_0_w_strb(w_strb), .io_axi4_0_w_last(w_last),
    .io_axi4_0_b_valid(b_valid), .io_axi4_0_b_ready(b_ready), .io_axi4_0_b_id(b_id),
    .io_axi4_0_b_resp(b_resp),
    .io_axi4_0_ar_valid(ar_valid), .io_axi4_0_ar_ready(ar_ready), .io_axi4_0_ar_id(ar_id),
    .io_axi4_0_ar_addr(ar_addr), .io_axi4_0_ar_len(ar_len), .io_axi4_0_ar_size(ar_size),
    .io_axi4_0_ar_burst(ar_burst), .io_axi4_0_ar_lock(ar_lock), .io_axi4_0_ar_cache(ar_cache),
    .io_axi4_0_ar_prot(ar_prot), .io_axi4_0_ar_qos(ar_qos),
    .io_axi4_0_r_valid(r_valid), .io_axi4_0_r_ready(r_ready), .io_axi4_0_r_id(r_id),
    .io_axi4_0_r_data(r_data), .io_axi4_0_r_resp(r_resp), .io_axi4_0_r_last(r_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Scoreboard queues
  logic [40:0] exp_a[$];     // {write, masked addr, len}
  logic [72:0] exp_w[$];     // {data, strb, last}
  logic [64:0] exp_r[$];     // {data, last}
  logic        exp_done[$];  // expected done_err
  logic [63:0] ref_mem[int];

  // Slave knobs
  logic [1:0] slv_bresp = 2'b00;
  bit         r_gaps = 0;
  bit         rd_stall = 0;
  int         early_idx = -1;

  // Behavioural zero-wait AXI4 slave. Samples handshakes at negedge and
  // updates its outputs just after the following posedge.
  logic [63:0] mem [0:1023];
  initial begin
    bit s_aw, s_w, s_b, s_ar, s_r, s_wl;
    logic [31:0] s_awa, s_ara, wr_ptr, rd_ptr;
    logic [63:0] s_wd;
    logic [7:0]  s_arl;
    int rd_left, rd_idx;
    aw_ready = 1'b1; w_ready = 1'b1; ar_ready = 1'b1;
    b_valid = 1'b0; b_id = 4'h0; b_resp = 2'b00;
    r_valid = 1'b0; r_id = 4'h0; r_data = '0; r_resp = 2'b00; r_last = 1'b0;
    wr_ptr = '0; rd_ptr = '0; rd_left = 0; rd_idx = 0;
    forever begin
      @(negedge clock);
      s_aw = aw_valid && aw_ready;  s_awa = aw_addr;
      s_w  = w_valid && w_ready;    s_wd = w_data;  s_wl = w_last;
      s_b  = b_valid && b_ready;
      s_ar = ar_valid && ar_ready;  s_ara = ar_addr; s_arl = ar_len;
      s_r  = r_valid && r_ready;
      @(posedge clock);
      #1;
      if (!resetn) begin
        b_valid = 1'b0; r_valid = 1'b0; r_last = 1'b0; rd_left = 0;
      end else begin
        if (s_aw) wr_ptr = s_awa;
        if (s_b) b_valid = 1'b0;
        if (s_w) begin
          mem[int'((wr_ptr >> 3) & 32'd1023)] = s_wd;
          wr_ptr = wr_ptr + 32'd8;
          if (s_wl) begin b_valid = 1'b1; b_resp = slv_bresp; end
        end
        if (s_ar) begin rd_ptr = s_ara; rd_left = int'(s_arl) + 1; rd_idx = 0; end
        if (s_r) begin
          rd_left--;
          if (r_last) rd_left = 0;
          rd_idx++;
          r_valid = 1'b0;
        end
        if (!r_valid && rd_left > 0 && (!r_gaps || $urandom_range(0, 2) != 0)) begin
          r_valid = 1'b1;
          r_data  = mem[int'(((rd_ptr >> 3) + 32'(rd_idx)) & 32'd1023)];
          r_last  = (rd_left == 1) || (rd_idx == early_idx);
        end
      end
    end
  end

  // Downstream read consumer, optionally stalling.
  initial begin
    rdata_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      rdata_ready = rd_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents something.
  always @(negedge clock) begin
    logic [40:0] ea;
    logic [72:0] ew;
    logic [64:0] er;
    if (resetn === 1'b1) begin
      if (aw_valid && aw_ready) begin
        if (exp_a.size() == 0) fail_now("aw_unexpected");
        else begin ea = exp_a.pop_front(); check("aw_addr_len", {1'b1, aw_addr, aw_len}, ea); end
        check("aw_const", {aw_id, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos},
              {4'h0, 3'd3, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0});
      end
      if (ar_valid && ar_ready) begin
        if (exp_a.size() == 0) fail_now("ar_unexpected");
        else begin ea = exp_a.pop_front(); check("ar_addr_len", {1'b0, ar_addr, ar_len}, ea); end
        check("ar_const", {ar_id, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos},
              {4'h0, 3'd3, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0});
      end
      if (w_valid && w_ready) begin
        if (exp_w.size() == 0) fail_now("w_unexpected");
        else begin ew = exp_w.pop_front(); check("w_beat", {w_data, w_strb, w_last}, ew); end
      end
      if (rdata_valid && rdata_ready) begin
        if (exp_r.size() == 0) fail_now("r_unexpected");
        else begin er = exp_r.pop_front(); check("r_beat", {rdata, rdata_last}, er); end
      end
      if (done_valid) begin
        check("done_cmd_ready", cmd_ready, 1'b0);
        if (exp_done.size() == 0) fail_now("done_unexpected");
        else check("done_err", done_err, exp_done.pop_front());
        done_cnt++;
      end
    end
  end

  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                         input logic [63:0] base, input logic exp_err, input bit no_axi,
                         input int early, input int abort_at);
    logic [31:0] ma;
    logic [63:0] d;
    int n, start, nb;
    ma = addr & 32'h07ff_ffff;
    start = done_cnt;
    if (!no_axi) exp_a.push_back({wr, ma, len});
    if (abort_at < 0) exp_done.push_back(exp_err);
    if (!no_axi && wr) begin
      for (int i = 0; i <= int'(len); i++) begin
        d = 64'(i + 1) * base;
        exp_w.push_back({d, 8'(i) ^ 8'hff, i == int'(len)});
        ref_mem[int'(ma >> 3) + i] = d;
      end
    end
    if (!no_axi && !wr) begin
      nb = (early >= 0) ? early : int'(len);
      for (int i = 0; i <= nb; i++)
        exp_r.push_back({ref_mem[int'(ma >> 3) + i], (i == int'(len)) || (i == early)});
    end
    cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!cmd_ready && n < 100) begin @(negedge clock); n++; end
    if (!cmd_ready) fail_now("cmd_accept_timeout");
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    if (no_axi) begin
      @(negedge clock);
      check("errpath_done_valid", done_valid, 1'b1);
      check("errpath_done_err", done_err, 1'b1);
    end
    if (!no_axi && wr) begin
      for (int i = 0; i <= int'(len); i++) begin
        wdata = 64'(i + 1) * base;
        wstrb = 8'(i) ^ 8'hff;
        wdata_valid = 1'b1;
        if (i == abort_at) begin
          #1;
          check("pre_reset_w_valid", w_valid, 1'b1);
          resetn = 1'b0;
          #1;
          check("reset_w_valid_drop", w_valid, 1'b0);
          check("reset_aw_valid_drop", aw_valid, 1'b0);
          check("reset_cmd_ready", cmd_ready, 1'b0);
          wdata_valid = 1'b0;
          exp_a.delete(); exp_w.delete(); exp_r.delete(); exp_done.delete();
          return;
        end
        n = 0;
        @(negedge clock);
        while (!wdata_ready && n < 100) begin @(negedge clock); n++; end
        if (!wdata_ready) begin fail_now("wdata_timeout"); break; end
        @(posedge clock);
        #1;
      end
      wdata_valid = 1'b0;
    end
    n = 0;
    while (done_cnt == start && n < 3000) begin @(negedge clock); n++; end
    if (done_cnt == start) fail_now("done_timeout");
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0; wstrb = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_outputs", {cmd_ready, aw_valid, ar_valid, w_valid, wdata_ready, b_ready,
                            r_ready, rdata_valid, done_valid, done_err}, 10'd0);
    resetn = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("idle_cmd_ready", cmd_ready, 1'b1);
    @(posedge clock);
    #1;

    // Write 0x11..0x44 then read it back.
    run_cmd(1'b1, 32'h0000_1000, 8'd3, 64'h11, 1'b0, 0, -1, -1);
    run_cmd(1'b0, 32'h0000_1000, 8'd3, 64'h0, 1'b0, 0, -1, -1);

    // Masked read with slave gaps and consumer stalls.
    run_cmd(1'b1, 32'h0000_0040, 8'd7, 64'ha5a5_0000_0000_0007, 1'b0, 0, -1, -1);
    r_gaps = 1; rd_stall = 1;
    run_cmd(1'b0, 32'h8000_0040, 8'd7, 64'h0, 1'b0, 0, -1, -1);
    r_gaps = 0; rd_stall = 0;

    // 4 KB crossing and misalignment: no AXI traffic, error completion.
    run_cmd(1'b1, 32'h0000_0ff8, 8'd1, 64'h1, 1'b1, 1, -1, -1);
    run_cmd(1'b0, 32'h0000_0ff8, 8'd1, 64'h0, 1'b1, 1, -1, -1);
    run_cmd(1'b0, 32'h0000_1004, 8'd0, 64'h0, 1'b1, 1, -1, -1);
    // Burst ending exactly on the page boundary is legal.
    run_cmd(1'b1, 32'h0000_0ff8, 8'd0, 64'h0f0f, 1'b0, 0, -1, -1);

    // SLVERR write response, then early r_last, then a clean command.
    slv_bresp = 2'b10;
    run_cmd(1'b1, 32'h0000_0200, 8'd1, 64'h3c3c, 1'b1, 0, -1, -1);
    slv_bresp = 2'b00;
    early_idx = 1;
    run_cmd(1'b0, 32'h0000_1000, 8'd3, 64'h0, 1'b1, 0, 1, -1);
    early_idx = -1;
    run_cmd(1'b0, 32'h0000_0200, 8'd1, 64'h0, 1'b0, 0, -1, -1);

    // Reset during beat 5 of a 16-beat write.
    run_cmd(1'b1, 32'h0000_0100, 8'd15, 64'h77, 1'b0, 0, -1, 4);
    repeat (3) @(posedge clock);
    #3;
    resetn = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("post_reset_cmd_ready", cmd_ready, 1'b1);
    @(posedge clock);
    #1;

    // Maximum-length bursts.
    run_cmd(1'b1, 32'h0000_2000, 8'd255, 64'h0101_0101_0000_0001, 1'b0, 0, -1, -1);
    rd_stall = 1;
    run_cmd(1'b0, 32'h0000_2000, 8'd255, 64'h0, 1'b0, 0, -1, -1);
    rd_stall = 0;

    repeat (4) @(posedge clock);
    check("exp_a_empty", 128'(exp_a.size()), 128'd0);
    check("exp_w_empty", 128'(exp_w.size()), 128'd0);
    check("exp_r_empty", 128'(exp_r.size()), 128'd0);
    check("exp_done_empty", 128'(exp_done.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
